dbg_stream_loader: RTL and testbench
====================================

// Module: dbg_stream_loader
// PURPOSE
//  Host-side initiator for the core debug command interface (cmd/addr/data/ready). Receives byte frames
//  from a host link (UART RX or similar byte stream), drives one debug command per frame into the debug
//  module, waits for its ready, and returns an ACK (plus read data) on a byte TX stream.
//  Sits between the host link and the debug port of the core wrapper; used for program load and memory peek/poke.
// PARAMETERS
//  SYNC_BYTE   8'hA5  frame start byte; all other bytes are dropped while hunting for sync
//  READ_CMD    8'h01  command code whose response carries 4 read-data bytes
//  ACK_BYTE    8'h5A  response byte for a completed command
//  NAK_BYTE    8'hEE  response byte for a command that timed out
//  TIMEOUT     1024   max cycles to wait for dbg_ready_i (>=2); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1   clock
//  rst_i        in   1   synchronous reset, active high
//  rx_data_i    in   8   host byte in
//  rx_valid_i   in   1   rx_data_i valid
//  rx_ready_o   out  1   byte accepted when rx_valid_i & rx_ready_o at posedge
//  tx_data_o    out  8   response byte out
//  tx_valid_o   out  1   tx_data_o valid; held with data stable until tx_ready_i
//  tx_ready_i   in   1   host link accepts tx byte
//  dbg_cmd_o    out  8   debug command; 8'h00 = NOP
//  dbg_addr_o   out  32  debug address
//  dbg_data_o   out  32  debug write data
//  dbg_data_i   in   32  debug read data, valid in the cycle dbg_ready_i is high
//  dbg_ready_i  in   1   debug module completion
//  busy_o       out  1   high in every state except SYNC
//  timeout_o    out  1   sticky: set on any timeout, cleared only by rst_i
// BEHAVIOUR
//  Frame: SYNC_BYTE, CMD, ADDR[7:0..31:24], DATA[7:0..31:24] (10 bytes, little endian). CMD=0 is legal: no issue, ACK only.
//  Reset (rst_i high at posedge): state=SYNC; rx_ready_o=0 during the reset cycle, 1 after; tx_valid_o=0, tx_data_o=0,
//   dbg_cmd_o=0, dbg_addr_o=0, dbg_data_o=0, busy_o=0, timeout_o=0, byte index=0, timeout counter=0.
//   Reset mid-frame or mid-command discards everything; dbg_cmd_o returns to 0 in the cycle after reset.
//  States:
//   SYNC   rx_ready_o=1; accepted byte==SYNC_BYTE -> CMD, else stay (byte dropped).
//   CMD    rx_ready_o=1; accepted byte latched as pending cmd -> ADDR (idx=0).
//   ADDR   rx_ready_o=1; accepted byte into dbg_addr_o[8*idx+:8]; idx==3 -> DATA (idx=0).
//   DATA   rx_ready_o=1; accepted byte into dbg_data_o[8*idx+:8]; idx==3 -> ISSUE (cmd!=0) or RESP (cmd==0).
//   ISSUE  rx_ready_o=0; dbg_cmd_o=pending cmd, addr/data stable; counter increments each cycle.
//          dbg_ready_i=1 -> capture dbg_data_i, dbg_cmd_o=0 next cycle, -> RESP.
//          counter reaches TIMEOUT with no ready -> dbg_cmd_o=0, timeout_o=1, response=NAK, -> RESP.
//          Ready in the same cycle the counter hits TIMEOUT counts as success.
//   RESP   rx_ready_o=0; send ACK (or NAK); if success and cmd==READ_CMD, then 4 read bytes LSB first.
//          Each byte held on tx_data_o with tx_valid_o=1 until tx_ready_i; next byte presented the following cycle
//          (tx_valid_o may stay high across bytes). After last byte handshake -> GAP.
//   GAP    one cycle, dbg_cmd_o=0, rx_ready_o=0 -> SYNC. Guarantees >=1 NOP cycle between debug commands.
//  dbg_ready_i is ignored outside ISSUE. Bytes offered while rx_ready_o=0 are not consumed (host backpressured).
//  Only one frame in flight; no rx buffering. Latency: dbg_cmd_o asserts the cycle after the last DATA byte is accepted.
//  busy_o = (state != SYNC); all outputs registered.
// TESTING
//  1 Write: A5 02 00 40 00 00 EF BE AD DE, ready after 3 cycles -> dbg_cmd_o=02, addr=0x4000, data=0xDEADBEEF for
//    exactly the ISSUE cycles, then tx = 5A only; dbg_cmd_o=0 >=1 cycle after.
//  2 Read: A5 01 10 00 00 00 00 00 00 00, ready with dbg_data_i=0x12345678 -> tx = 5A 78 56 34 12.
//  3 Garbage: 00 FF A4 then valid frame -> garbage dropped, frame executed normally, single ACK.
//  4 Timeout: TIMEOUT=8, write frame, dbg_ready_i never high -> cmd low after 8 ISSUE cycles, tx = EE, timeout_o=1 sticky;
//    next read frame succeeds with 5A + data and timeout_o still 1.
//  5 TX backpressure: read frame, tx_ready_i low 5 cycles per byte -> each byte stable while tx_valid_o high; rx_ready_o=0
//    throughout; no byte lost or duplicated.
//  6 Reset mid-ISSUE and mid-ADDR: rst_i pulse -> all outputs at reset values next cycle, subsequent frame decodes from SYNC.

Source files
------------

// File: rtl/dbg_stream_loader.sv
// Host byte-stream to debug-port bridge: decodes 10-byte frames, issues one debug
// command per frame, and answers with ACK/NAK (plus read data) on the TX byte stream.
module dbg_stream_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] READ_CMD  = 8'h01,
    parameter logic [7:0] ACK_BYTE  = 8'h5A,
    parameter logic [7:0] NAK_BYTE  = 8'hEE,
    parameter int         TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);
    // Handshakes: a byte moves on rx when rx_valid_i & rx_ready_o at posedge, and on tx
    // when tx_valid_o & tx_ready_i at posedge; tx_data_o is held stable while waiting.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SYNC, S_CMD, S_ADDR, S_DATA, S_ISSUE, S_RESP, S_GAP
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [7:0]    cmd_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          rd_resp;
    logic [2:0]    tx_idx;
    logic          accept;

    assign accept = rx_valid_i & rx_ready_o;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state      <= S_SYNC;
            idx        <= 2'd0;
            cmd_q      <= 8'h00;
            cnt        <= '0;
            rdata_q    <= 32'h0;
            rd_resp    <= 1'b0;
            tx_idx     <= 3'd0;
            rx_ready_o <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            dbg_cmd_o  <= 8'h00;
            dbg_addr_o <= 32'h0;
            dbg_data_o <= 32'h0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            case (state)
                S_SYNC: begin
                    rx_ready_o <= 1'b1;
                    if (accept && rx_data_i == SYNC_BYTE) begin
                        state  <= S_CMD;
                        busy_o <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (accept) begin
                        cmd_q <= rx_data_i;
                        idx   <= 2'd0;
                        state <= S_ADDR;
                    end
                end
                // Bytes shift in from the top so the first (LSB) byte ends in [7:0].
                S_ADDR: begin
                    if (accept) begin
                        dbg_addr_o <= {rx_data_i, dbg_addr_o[31:8]};
                        idx        <= idx + 2'd1;
                        if (idx == 2'd3) state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        dbg_data_o <= {rx_data_i, dbg_data_o[31:8]};
                        idx        <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            rx_ready_o <= 1'b0;
                            cnt        <= '0;
                            if (cmd_q != 8'h00) begin
                                dbg_cmd_o <= cmd_q;
                                state     <= S_ISSUE;
                            end else begin
                                tx_valid_o <= 1'b1;
                                tx_data_o  <= ACK_BYTE;
                                rd_resp    <= 1'b0;
                                tx_idx     <= 3'd0;
                                state      <= S_RESP;
                            end
                        end
                    end
                end
                // Ready is checked before the limit so a same-cycle ready still succeeds.
                S_ISSUE: begin
                    cnt <= cnt + CW'(1);
                    if (dbg_ready_i) begin
                        rdata_q    <= dbg_data_i;
                        dbg_cmd_o  <= 8'h00;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= ACK_BYTE;
                        rd_resp    <= (cmd_q == READ_CMD);
                        tx_idx     <= 3'd0;
                        state      <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        dbg_cmd_o  <= 8'h00;
                        timeout_o  <= 1'b1;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= NAK_BYTE;
                        rd_resp    <= 1'b0;
                        tx_idx     <= 3'd0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (tx_ready_i) begin
                        if (!rd_resp || tx_idx == 3'd4) begin
                            tx_valid_o <= 1'b0;
                            tx_data_o  <= 8'h00;
                            state      <= S_GAP;
                        end else begin
                            tx_idx    <= tx_idx + 3'd1;
                            tx_data_o <= rdata_q[7:0];
                            rdata_q   <= {8'h00, rdata_q[31:8]};
                        end
                    end
                end
                S_GAP: begin
                    rx_ready_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= S_SYNC;
                end
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_stream_loader.sv
// Randomized frame-level bench for dbg_stream_loader with a transaction-level
// response model, a debug-port responder and a TX byte scoreboard.
module tb_dbg_stream_loader;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i = 32'h0;
    logic        dbg_ready_i = 1'b0;
    logic        busy_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    dbg_stream_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
        .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  exp_cmd;
    logic [31:0] exp_addr, exp_data, rsp_data;
    int          rsp_lat = 0;
    int          hi_cnt = 0;
    int          bp_mode = 1;
    int          wait_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          model_tmo = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Debug responder and TX sink, both acting on the falling edge.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_hold   = 1'b0;
            dbg_ready_i = 1'b0;
            tx_ready_i  = 1'b0;
            wait_cnt    = 0;
        end else begin
            if (dbg_cmd_o != 8'h00) begin
                hi_cnt++;
                check("dbg_cmd", 32'(dbg_cmd_o), 32'(exp_cmd));
                check("dbg_addr", dbg_addr_o, exp_addr);
                check("dbg_data", dbg_data_o, exp_data);
                check("rx_ready_issue", 32'(rx_ready_o), 32'd0);
                if (hi_cnt == rsp_lat) begin
                    dbg_ready_i = 1'b1;
                    dbg_data_i  = rsp_data;
                end else begin
                    dbg_ready_i = 1'b0;
                    dbg_data_i  = $urandom;
                end
            end else begin
                dbg_ready_i = 1'($urandom_range(0, 1));
                dbg_data_i  = $urandom;
            end
            if (prev_hold) begin
                check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
                check("tx_hold_data", 32'(tx_data_o), 32'(prev_data));
            end
            if (tx_valid_o) begin
                check("rx_ready_resp", 32'(rx_ready_o), 32'd0);
                check("busy_resp", 32'(busy_o), 32'd1);
                case (bp_mode)
                    0: tx_ready_i = 1'($urandom_range(0, 1));
                    2: tx_ready_i = (wait_cnt >= 5);
                    default: tx_ready_i = 1'b1;
                endcase
                if (tx_ready_i) begin
                    wait_cnt = 0;
                    got_q.push_back(tx_data_o);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt   = 0;
                tx_ready_i = 1'($urandom_range(0, 1));
            end
            prev_hold = tx_valid_o && !tx_ready_i;
            prev_data = tx_data_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_dbg_cmd", 32'(dbg_cmd_o), 32'd0);
        check("rst_dbg_addr", dbg_addr_o, 32'd0);
        check("rst_dbg_data", dbg_data_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        rst_i     = 1'b0;
        model_tmo = 1'b0;
        hi_cnt    = 0;
        got_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] fr[10];
        fr = '{8'hA5, c, a[7:0], a[15:8], a[23:16], a[31:24],
               d[7:0], d[15:8], d[23:16], d[31:24]};
        for (int i = 0; i < 10; i++) send_byte(fr[i]);
    endtask

    // Model: one response per frame; success iff ready arrives within TMO cycles.
    task automatic run_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input logic [31:0] rd, input int mode);
        int n;
        int exp_hi;
        logic [31:0] tmp;
        exp_cmd = c; exp_addr = a; exp_data = d;
        rsp_lat = lat; rsp_data = rd; bp_mode = mode;
        hi_cnt = 0;
        got_q.delete();
        exp_q.delete();
        if (c == 8'h00) begin
            exp_q.push_back(8'h5A);
            exp_hi = 0;
        end else if (lat <= TMO) begin
            exp_q.push_back(8'h5A);
            tmp = rd;
            if (c == 8'h01)
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back(tmp[7:0]);
                    tmp = tmp >> 8;
                end
            exp_hi = lat;
        end else begin
            exp_q.push_back(8'hEE);
            model_tmo = 1'b1;
            exp_hi = TMO;
        end
        send_frame(c, a, d);
        n = 0;
        while (busy_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("frame_done", 32'(n < 500), 32'd1);
        check("tx_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("tx_byte", 32'(got_q[i]), 32'(exp_q[i]));
        check("cmd_cycles", 32'(hi_cnt), 32'(exp_hi));
        check("timeout_flag", 32'(timeout_o), 32'(model_tmo));
        check("rx_ready_idle", 32'(rx_ready_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int r;
        do_reset();
        run_frame(8'h02, 32'h0000_4000, 32'hDEAD_BEEF, 3, 32'h0, 1);
        run_frame(8'h01, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 1);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA4);
        run_frame(8'h02, 32'h0000_1234, 32'hCAFE_F00D, 1, 32'h0, 0);
        run_frame(8'h02, 32'h0000_2000, 32'h5555_AAAA, 1000, 32'h0, 1);
        run_frame(8'h01, 32'h0000_2004, 32'h0, 2, 32'hA1B2_C3D4, 1);
        run_frame(8'h01, 32'h0000_2008, 32'h0, TMO, 32'h0BAD_F00D, 0);
        run_frame(8'h01, 32'h0000_0020, 32'h0, 4, 32'h8765_4321, 2);
        run_frame(8'h00, 32'h1111_1111, 32'h2222_2222, 1, 32'h0, 0);

        // Reset in the middle of an address field.
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11); send_byte(8'h22);
        do_reset();
        run_frame(8'h03, 32'h0000_3000, 32'h0000_0003, 2, 32'h0, 1);

        // Reset while a command is being issued.
        exp_cmd = 8'h02; exp_addr = 32'h0000_5000; exp_data = 32'h0000_0055;
        rsp_lat = 1000; hi_cnt = 0;
        send_frame(8'h02, 32'h0000_5000, 32'h0000_0055);
        @(negedge clk); @(negedge clk);
        check("issue_before_reset", 32'(dbg_cmd_o), 32'h02);
        do_reset();
        run_frame(8'h01, 32'h0000_5004, 32'h0, 3, 32'hFEED_FACE, 1);

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 3);
            c = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'h02 : 8'($urandom);
            run_frame(c, $urandom, $urandom, $urandom_range(1, 11), $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
